lane_mem_ctrl: RTL

- Parametrised next-generation per-lane memory controller for the SM core.
- Sits between the scheduler's memory strobes (mread/mwrite/mready) and N SP lanes on one side, and a single-port data memory on the other.
- Serialises masked lane accesses onto the shared memory port, adding:
  - configurable lane count, data width and address width;
  - a variable-latency memory handshake (mem_ack);
  - optional read coalescing of identical lane addresses.

---
 rtl/lane_mem_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/lane_mem_ctrl.sv
// Per-lane memory controller: serialises the masked lane accesses of one
// scheduler request onto a single-port data memory with a variable-latency
// ack. Reads to identical lane addresses can be merged into one access.
module lane_mem_ctrl #(
  parameter int N_LANES  = 4,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int COALESCE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mread,
  input  logic                        mwrite,
  output logic                        mready,
  input  logic [N_LANES-1:0]          en_mask,
  input  logic [N_LANES*ADDR_W-1:0]   lane_addr,
  input  logic [N_LANES*DATA_W-1:0]   lane_wdata,
  output logic [N_LANES*DATA_W-1:0]   lane_rdata,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        mem_re,
  output logic                        mem_we,
  input  logic                        mem_ack
);

  localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

  state_e              state_q, state_d;
  logic [N_LANES-1:0]  pend_q, pend_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic                is_rd_q, is_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_re_q, mem_re_d;
  logic                mem_we_q, mem_we_d;
  logic                mready_q, mready_d;
  logic                busy_q, busy_d;

  // Latched per-lane request and per-lane read results
  logic [ADDR_W-1:0]   addr_q  [N_LANES];
  logic [DATA_W-1:0]   wdata_q [N_LANES];
  logic [DATA_W-1:0]   rdata_q [N_LANES];

  logic [ADDR_W-1:0]   in_addr  [N_LANES];
  logic [DATA_W-1:0]   in_wdata [N_LANES];

  logic [N_LANES-1:0]  sel_1h;   // lane currently on the memory port
  logic [N_LANES-1:0]  hit;      // lanes served by the current read
  logic [N_LANES-1:0]  clr;      // pending bits retired on ack
  logic [N_LANES-1:0]  rem;      // pending lanes left after this ack
  logic [N_LANES-1:0]  rd_load;  // lanes capturing mem_rdata this cycle
  logic                accept;
  logic [IDX_W-1:0]    first_idx, next_idx;

  // Priority encoder: lowest set bit of the mask
  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_LANES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign in_addr[gi]  = lane_addr[gi*ADDR_W +: ADDR_W];
    assign in_wdata[gi] = lane_wdata[gi*DATA_W +: DATA_W];
    assign sel_1h[gi]   = (cur_q == IDX_W'(gi));

    if (COALESCE != 0) begin : g_coal
      assign hit[gi] = pend_q[gi] && (addr_q[gi] == addr_q[cur_q]);
    end else begin : g_single
      assign hit[gi] = sel_1h[gi];
    end

    // Capture the lane's address and write data when a request is accepted
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        addr_q[gi]  <= '0;
        wdata_q[gi] <= '0;
      end else if (accept) begin
        addr_q[gi]  <= in_addr[gi];
        wdata_q[gi] <= in_wdata[gi];
      end
    end

    // Lane read result; only overwritten by an acked read that serves this lane
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rdata_q[gi] <= '0;
      end else if (rd_load[gi]) begin
        rdata_q[gi] <= mem_rdata;
      end
    end

    assign lane_rdata[gi*DATA_W +: DATA_W] = rdata_q[gi];
  end

  assign clr       = is_rd_q ? hit : sel_1h;
  assign rem       = pend_q & ~clr;
  assign first_idx = lowest_set(en_mask);
  assign next_idx  = lowest_set(rem);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cur_d       = cur_q;
    is_rd_d     = is_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mready_d    = 1'b0;
    busy_d      = busy_q;
    accept      = 1'b0;
    rd_load     = '0;

    unique case (state_q)
      IDLE: begin
        if (mread || mwrite) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          is_rd_d = mread;          // read wins if both strobes are set
          pend_d  = en_mask;
          if (en_mask != '0) begin
            // Launch the first access straight away so its strobe is up next cycle
            state_d     = ISSUE;
            cur_d       = first_idx;
            mem_addr_d  = in_addr[first_idx];
            mem_wdata_d = in_wdata[first_idx];
            mem_re_d    = mread;
            mem_we_d    = !mread;
          end else begin
            state_d  = DONE;
            mready_d = 1'b1;
          end
        end
      end

      ISSUE: begin
        if (mem_ack) begin
          if (is_rd_q) rd_load = hit;
          pend_d = rem;
          if (rem == '0) begin
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
            state_d  = DONE;
            mready_d = 1'b1;
          end else begin
            // Back-to-back: next lane's access is presented without a gap
            cur_d       = next_idx;
            mem_addr_d  = addr_q[next_idx];
            mem_wdata_d = wdata_q[next_idx];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Control state register; reset aborts any request in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      cur_q       <= '0;
      is_rd_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mready_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cur_q       <= cur_d;
      is_rd_q     <= is_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mready_q    <= mready_d;
      busy_q      <= busy_d;
    end
  end

  assign mready    = mready_q;
  assign busy      = busy_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;

endmodule
